// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 4-register CPU: opcodes, execute-stage
// state encoding and datapath widths.
package cpu_pkg;

  localparam int WORD_W    = 16;
  localparam int REG_IDX_W = 2;
  localparam int OP_W      = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_DIVU = 3'b110,
    ALU_REMU = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

  // Divide by zero bypasses the iterator and resolves in one cycle.
  function automatic logic is_iterative(input alu_op_t op, input logic b_zero);
    return (op == ALU_MUL) || (((op == ALU_DIVU) || (op == ALU_REMU)) && !b_zero);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier and restoring unsigned divider, one bit per
// step. Outputs are the values produced by the step taken this cycle.
module iter_muldiv #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         last_step,
  output logic [W-1:0] product,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CNT_W = $clog2(W);

  logic [CNT_W-1:0] count;
  logic [W-1:0]     acc;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     divisor;
  logic [W:0]       rem_shift;
  logic [W-1:0]     diff;
  logic             q_bit;

  // When the trial subtraction succeeds the true difference is below the
  // divisor, so the low W bits of the wrapped subtraction are exact.
  always_comb begin
    rem_shift = {rem, quo[W-1]};
    q_bit     = (rem_shift >= {1'b0, divisor});
    diff      = rem_shift[W-1:0] - divisor;
    remainder = q_bit ? diff : rem_shift[W-1:0];
    quotient  = {quo[W-2:0], q_bit};
    product   = acc + (mplier[0] ? mcand : '0);
  end

  assign last_step = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= CNT_W'(W - 1);
    else if (step && (count != '0))
      count <= count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      rem     <= '0;
      quo     <= a;
      divisor <= b;
    end else if (step) begin
      if (is_div) begin
        rem <= remainder;
        quo <= quotient;
      end else begin
        acc    <= product;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIVU/REMU behind a
// start/busy/done handshake; drives the register-file write port.
module alu_execute_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [OP_W-1:0]      AluOp,
  input  logic [WIDTH-1:0]     OperandA,
  input  logic [WIDTH-1:0]     OperandB,
  input  logic [REG_IDX_W-1:0] DestIn,
  output logic                 Busy,
  output logic                 Done,
  output logic                 RegWrite,
  output logic [WIDTH-1:0]     Result,
  output logic [REG_IDX_W-1:0] DestOut,
  output logic                 Zero,
  output logic                 DivByZero
);

  exec_state_t      state;
  exec_state_t      state_next;
  alu_op_t          op_in;
  alu_op_t          op_q;
  logic             accept;
  logic             b_zero;
  logic             iterative;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] iter_res;
  logic             last_step;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  function automatic logic [WIDTH-1:0] alu_simple(input alu_op_t op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
      ALU_DIVU: return '1;
      ALU_REMU: return a;
      default:  return '0;
    endcase
  endfunction

  assign op_in      = alu_op_t'(AluOp);
  assign accept     = Start && (state == ST_IDLE);
  assign b_zero     = (OperandB == '0);
  assign iterative  = is_iterative(op_in, b_zero);
  assign simple_res = alu_simple(op_in, OperandA, OperandB);
  assign iter_res   = (op_q == ALU_MUL)  ? product  :
                      (op_q == ALU_DIVU) ? quotient : remainder;

  iter_muldiv #(.W(WIDTH)) u_iter (
    .clk       (Clock),
    .rst       (Reset),
    .load      (accept && iterative),
    .step      (state == ST_ITER),
    .is_div    (op_q != ALU_MUL),
    .a         (OperandA),
    .b         (OperandB),
    .last_step (last_step),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = iterative ? ST_ITER : ST_DONE;
      ST_ITER: if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign Busy     = (state != ST_IDLE);
  assign Done     = (state == ST_DONE);
  assign RegWrite = Done;

  // Result and its flags only change on a single-cycle accept or the final step.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q      <= ALU_ADD;
      Result    <= '0;
      DestOut   <= '0;
      Zero      <= 1'b0;
      DivByZero <= 1'b0;
    end else if (accept) begin
      op_q    <= op_in;
      DestOut <= DestIn;
      if (!iterative) begin
        Result    <= simple_res;
        Zero      <= (simple_res == '0);
        DivByZero <= ((op_in == ALU_DIVU) || (op_in == ALU_REMU)) && b_zero;
      end
    end else if ((state == ST_ITER) && last_step) begin
      Result    <= iter_res;
      Zero      <= (iter_res == '0);
      DivByZero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Self-checking bench for alu_execute_unit: directed vector table, random ops
// against an arithmetic reference model, and handshake/reset corner sequences.
module tb_alu_execute_unit;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [2:0]  AluOp;
  logic [15:0] OperandA;
  logic [15:0] OperandB;
  logic [1:0]  DestIn;
  logic        Busy;
  logic        Done;
  logic        RegWrite;
  logic [15:0] Result;
  logic [1:0]  DestOut;
  logic        Zero;
  logic        DivByZero;

  int checks;
  int failures;

  alu_execute_unit #(.WIDTH(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .AluOp     (AluOp),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .DestIn    (DestIn),
    .Busy      (Busy),
    .Done      (Done),
    .RegWrite  (RegWrite),
    .Result    (Result),
    .DestOut   (DestOut),
    .Zero      (Zero),
    .DivByZero (DivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  dest;
    logic [15:0] res;
    logic        zero;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic dbz, output int lat);
    logic [31:0] p;
    dbz = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd5: begin p = 32'(a) * 32'(b); r = p[15:0]; lat = 17; end
      3'd6: if (b == 16'd0) begin r = 16'hFFFF; dbz = 1'b1; end
            else begin r = a / b; lat = 17; end
      default: if (b == 16'd0) begin r = a; dbz = 1'b1; end
               else begin r = a % b; lat = 17; end
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (Busy !== 1'b0 && n < 40) begin
      @(posedge Clock); #1;
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'(Busy), 32'd0);
  endtask

  // Returns at #1 after the accepting edge, i.e. inside cycle T+1.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] dest);
    wait_idle();
    @(negedge Clock);
    Start = 1'b1; AluOp = op; OperandA = a; OperandB = b; DestIn = dest;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] dest, input logic [15:0] er,
                           input logic ez, input logic edbz, input int lat);
    int ndone = 0;
    int done_at = 0;
    int bad = 0;
    logic [15:0] r_done = 'x;
    logic [15:0] r_after = 'x;
    logic [1:0]  d_done = 'x;
    logic        z_done = 'x;
    logic        dbz_done = 'x;
    issue(op, a, b, dest);
    for (int k = 1; k <= lat + 2; k++) begin
      if (Busy !== (k <= lat)) bad++;
      if (RegWrite !== Done) bad++;
      if (Done === 1'b1) begin
        ndone++; done_at = k;
        r_done = Result; d_done = DestOut; z_done = Zero; dbz_done = DivByZero;
      end
      if (k == lat + 1) r_after = Result;
      @(posedge Clock); #1;
    end
    check({tag, "/done_cycle"}, 32'(done_at), 32'(lat));
    check({tag, "/done_count"}, 32'(ndone), 32'd1);
    check({tag, "/handshake"}, 32'(bad), 32'd0);
    check({tag, "/result"}, 32'(r_done), 32'(er));
    check({tag, "/dest"}, 32'(d_done), 32'(dest));
    check({tag, "/zero"}, 32'(z_done), 32'(ez));
    check({tag, "/divbyzero"}, 32'(dbz_done), 32'(edbz));
    check({tag, "/held"}, 32'(r_after), 32'(er));
  endtask

  vec_t vecs[14];

  initial begin
    int ndone;
    int bad;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  dest;

    checks = 0; failures = 0;
    Reset = 1'b1; Start = 1'b0; AluOp = '0; OperandA = '0; OperandB = '0; DestIn = '0;

    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 2'd2, 16'h8000, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd1, 16'd3,    16'd5,    2'd1, 16'hFFFE, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd4, 16'hFFFF, 16'h0001, 2'd3, 16'h0001, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd1, 16'd7,    16'd7,    2'd0, 16'h0000, 1'b1, 1'b0, 1};
    vecs[4]  = '{3'd5, 16'd300,  16'd300,  2'd1, 16'h5F90, 1'b0, 1'b0, 17};
    vecs[5]  = '{3'd6, 16'd100,  16'd7,    2'd2, 16'd14,   1'b0, 1'b0, 17};
    vecs[6]  = '{3'd7, 16'd100,  16'd7,    2'd3, 16'd2,    1'b0, 1'b0, 17};
    vecs[7]  = '{3'd6, 16'd100,  16'd0,    2'd1, 16'hFFFF, 1'b0, 1'b1, 1};
    vecs[8]  = '{3'd7, 16'd1234, 16'd0,    2'd2, 16'h04D2, 1'b0, 1'b1, 1};
    vecs[9]  = '{3'd2, 16'hF0F0, 16'h0FF0, 2'd0, 16'h00F0, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd3, 16'hF0F0, 16'h0F0F, 2'd3, 16'hFFFF, 1'b0, 1'b0, 1};
    vecs[11] = '{3'd4, 16'h0001, 16'hFFFF, 2'd1, 16'h0000, 1'b1, 1'b0, 1};
    vecs[12] = '{3'd5, 16'hFFFF, 16'hFFFF, 2'd2, 16'h0001, 1'b0, 1'b0, 17};
    vecs[13] = '{3'd6, 16'hFFFF, 16'h0001, 2'd0, 16'hFFFF, 1'b0, 1'b0, 17};

    #12;
    check("reset_outputs", 32'({Busy, Done, RegWrite, Zero, DivByZero, DestOut, Result}), 32'd0);
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    check("idle_after_reset", 32'({Busy, Done}), 32'd0);

    for (int i = 0; i < 14; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
                vecs[i].res, vecs[i].zero, vecs[i].dbz, vecs[i].lat);

    for (int i = 0; i < 150; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      dest = 2'($urandom_range(0, 3));
      model(op, a, b, r, dbz, lat);
      run_check($sformatf("rnd%0d", i), op, a, b, dest, r, (r == 16'd0), dbz, lat);
    end

    // Start pulsed mid-iteration must be dropped.
    issue(3'd5, 16'd300, 16'd300, 2'd3);
    ndone = 0; bad = 0;
    for (int k = 1; k <= 22; k++) begin
      if (Done === 1'b1) begin
        ndone++;
        if (k != 17 || Result !== 16'h5F90 || DestOut !== 2'd3) bad++;
      end
      if (k == 5) begin
        @(negedge Clock);
        Start = 1'b1; AluOp = 3'd0; OperandA = 16'd1; OperandB = 16'd1; DestIn = 2'd0;
        @(posedge Clock); #1;
        Start = 1'b0;
      end else begin
        @(posedge Clock); #1;
      end
    end
    check("ignored_start/done_count", 32'(ndone), 32'd1);
    check("ignored_start/done_values", 32'(bad), 32'd0);
    check("ignored_start/result_kept", 32'(Result), 32'h5F90);

    // Start held into the DONE cycle is not accepted a second time.
    wait_idle();
    @(negedge Clock);
    Start = 1'b1; AluOp = 3'd0; OperandA = 16'd2; OperandB = 16'd3; DestIn = 2'd1;
    @(posedge Clock); #1;
    ndone = (Done === 1'b1) ? 1 : 0;
    @(posedge Clock); #1;
    Start = 1'b0;
    check("held_start/idle_after_done", 32'(Busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (Done === 1'b1) ndone++;
      @(posedge Clock); #1;
    end
    check("held_start/done_count", 32'(ndone), 32'd1);
    check("held_start/result", 32'(Result), 32'd5);

    // Asynchronous reset in the middle of a divide.
    run_check("pre_reset_add", 3'd0, 16'd1, 16'd1, 2'd3, 16'd2, 1'b0, 1'b0, 1);
    issue(3'd6, 16'd100, 16'd7, 2'd1);
    repeat (7) begin @(posedge Clock); #1; end
    check("mid_div/busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset/outputs", 32'({Busy, Done, RegWrite, Zero, DivByZero, DestOut, Result}), 32'd0);
    @(negedge Clock); Reset = 1'b0;
    ndone = 0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) ndone++;
      if (Busy !== 1'b0) bad++;
    end
    check("async_reset/no_done", 32'(ndone), 32'd0);
    check("async_reset/stays_idle", 32'(bad), 32'd0);
    run_check("post_reset_add", 3'd0, 16'd5, 16'd6, 2'd2, 16'h000B, 1'b0, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
